id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage RV32I core.
- Captures decoded fields from the decode stage (PC, immediate, opcode, funct3/funct7, register addresses, valid) on each rising clock edge and presents them to the execute stage.
- Supports stall (hold contents) and flush (insert bubble) driven by the hazard/branch unit.

---
 rtl/rv32i_pkg.sv | 33 +++
 rtl/pipe_field_reg.sv | 42 ++++
 rtl/id_ex_pipe_reg.sv | 121 ++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: datapath widths, opcode encodings and the
// pipeline-bubble field values that the pipeline registers clear to.
package rv32i_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;
  localparam int unsigned CNT_W  = 32;

  // Base opcode map
  localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;

  // Canonical NOP (addi x0, x0, 0) for reference by fetch/decode
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Bubble: invalid slot with all payload fields zero, so rd = x0
  localparam logic              BUBBLE_VALID  = 1'b0;
  localparam logic [OPC_W-1:0]  BUBBLE_OPCODE = 7'b0;
  localparam logic [F3_W-1:0]   BUBBLE_FUNC3  = 3'b0;
  localparam logic [F7_W-1:0]   BUBBLE_FUNC7  = 7'b0;
  localparam logic [REG_AW-1:0] BUBBLE_REG    = 5'd0;

endpackage

// File: rtl/pipe_field_reg.sv
// Single pipeline-register field.
//   clk, rst_ : clock and asynchronous active-high reset (loads RST_VAL)
//   en        : capture d on the rising edge (hold when low)
//   clr       : synchronous clear to CLR_VAL; takes priority over en
//   d / q     : field input / registered field output
module pipe_field_reg #(
  parameter int unsigned  W       = 1,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] field_d;
  logic [W-1:0] field_q;

  // Next value: clear > load > hold
  always_comb begin
    field_d = field_q;
    if (clr) begin
      field_d = CLR_VAL;
    end else if (en) begin
      field_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      field_q <= RST_VAL;
    end else begin
      field_q <= field_d;
    end
  end

  assign q = field_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register of the 5-stage RV32I core.
// Captures decoded fields each rising edge; stall holds, flush inserts a
// bubble (flush wins over stall). All outputs come straight from flops.
//   clk, rst_           : clock, asynchronous active-high reset
//   stall, flush        : hazard/branch unit controls
//   id_*, imm, opcode,
//   rd/rs1/rs2_addr,
//   func3, func7        : decode-stage fields
//   ex_*                : registered fields to the execute stage
// Optional build macro ID_EX_PERF_CNT_EN adds stall_cnt / flush_cnt,
// counting edges on which stall / flush was sampled high.
module id_ex_pipe_reg #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_AW   = 5,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   imm,
  input  logic [6:0]        opcode,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_imm,
  output logic [6:0]        ex_opcode,
  output logic [2:0]        ex_func3,
  output logic [6:0]        ex_func7,
  output logic [REG_AW-1:0] ex_rs1_addr,
  output logic [REG_AW-1:0] ex_rs2_addr,
  output logic [REG_AW-1:0] ex_rd_addr
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  import rv32i_pkg::*;

  logic load_en;

  assign load_en = ~stall;

  // Each field: reset and flush both produce the bubble value
  pipe_field_reg #(.W(1), .RST_VAL(BUBBLE_VALID), .CLR_VAL(BUBBLE_VALID)) u_valid (
    .clk(clk), .rst_(rst_), .en(load_en), .clr(flush), .d(id_valid), .q(ex_valid)
  );

  pipe_field_reg #(.W(XLEN), .RST_VAL(RESET_PC), .CLR_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst_(rst_), .en(load_en), .clr(flush), .d(id_pc), .q(ex_pc)
  );

  pipe_field_reg #(.W(XLEN), .RST_VAL('0), .CLR_VAL('0)) u_imm (
    .clk(clk), .rst_(rst_), .en(load_en), .clr(flush), .d(imm), .q(ex_imm)
  );

  pipe_field_reg #(.W(OPC_W), .RST_VAL(BUBBLE_OPCODE), .CLR_VAL(BUBBLE_OPCODE)) u_opcode (
    .clk(clk), .rst_(rst_), .en(load_en), .clr(flush), .d(opcode), .q(ex_opcode)
  );

  pipe_field_reg #(.W(F3_W), .RST_VAL(BUBBLE_FUNC3), .CLR_VAL(BUBBLE_FUNC3)) u_func3 (
    .clk(clk), .rst_(rst_), .en(load_en), .clr(flush), .d(func3), .q(ex_func3)
  );

  pipe_field_reg #(.W(F7_W), .RST_VAL(BUBBLE_FUNC7), .CLR_VAL(BUBBLE_FUNC7)) u_func7 (
    .clk(clk), .rst_(rst_), .en(load_en), .clr(flush), .d(func7), .q(ex_func7)
  );

  pipe_field_reg #(.W(REG_AW), .RST_VAL('0), .CLR_VAL('0)) u_rs1 (
    .clk(clk), .rst_(rst_), .en(load_en), .clr(flush), .d(rs1_addr), .q(ex_rs1_addr)
  );

  pipe_field_reg #(.W(REG_AW), .RST_VAL('0), .CLR_VAL('0)) u_rs2 (
    .clk(clk), .rst_(rst_), .en(load_en), .clr(flush), .d(rs2_addr), .q(ex_rs2_addr)
  );

  pipe_field_reg #(.W(REG_AW), .RST_VAL('0), .CLR_VAL('0)) u_rd (
    .clk(clk), .rst_(rst_), .en(load_en), .clr(flush), .d(rd_addr), .q(ex_rd_addr)
  );

`ifdef ID_EX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q;

  // Free-running event counters; natural wrap at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed testbench for id_ex_pipe_reg.
module tb_id_ex_pipe_reg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned OBS_W  = 1 + 32 + 32 + 7 + 3 + 7 + 5 + 5 + 5;
  localparam logic [OBS_W-1:0] BUBBLE_ALL =
    {1'b0, RESET_PC, 32'h0, 7'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0};

  logic              clk = 1'b0;
  logic              rst_ = 1'b1;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              id_valid = 1'b0;
  logic [31:0]       id_pc = '0;
  logic [31:0]       imm = '0;
  logic [6:0]        opcode = '0;
  logic [4:0]        rd_addr = '0;
  logic [4:0]        rs1_addr = '0;
  logic [4:0]        rs2_addr = '0;
  logic [2:0]        func3 = '0;
  logic [6:0]        func7 = '0;
  logic              ex_valid;
  logic [31:0]       ex_pc;
  logic [31:0]       ex_imm;
  logic [6:0]        ex_opcode;
  logic [2:0]        ex_func3;
  logic [6:0]        ex_func7;
  logic [4:0]        ex_rs1_addr;
  logic [4:0]        ex_rs2_addr;
  logic [4:0]        ex_rd_addr;
  logic [OBS_W-1:0]  obs_all;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_stall_cnt = '0;
  logic [31:0] exp_flush_cnt = '0;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_(rst_), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .imm(imm), .opcode(opcode),
    .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .func3(func3), .func7(func7),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_opcode(ex_opcode),
    .ex_func3(ex_func3), .ex_func7(ex_func7), .ex_rs1_addr(ex_rs1_addr),
    .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign obs_all = {ex_valid, ex_pc, ex_imm, ex_opcode, ex_func3, ex_func7,
                    ex_rs1_addr, ex_rs2_addr, ex_rd_addr};

  // Advance one rising edge, track expected counter values, sample 1 ns later
  task automatic tick();
    @(posedge clk);
    if (!rst_) begin
      if (stall) exp_stall_cnt = exp_stall_cnt + 32'd1;
      if (flush) exp_flush_cnt = exp_flush_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] im,
                       input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    id_valid = v; id_pc = pc; imm = im; opcode = opc;
    func3 = f3; func7 = f7; rs1_addr = r1; rs2_addr = r2; rd_addr = rd;
  endtask

  task automatic test_reset();
    drive(1'b1, 32'hABCD_0000, 32'h1234_5678, 7'b0110011, 3'h5, 7'h20, 5'd7, 5'd8, 5'd9);
    #2;
    tests_run++;
    if (obs_all !== BUBBLE_ALL) begin
      tests_failed++;
      $display("FAIL reset_async: got %h expected %h", obs_all, BUBBLE_ALL);
    end
    #10; // t=12 ns, one edge has passed while held in reset
    tests_run++;
    if (obs_all !== BUBBLE_ALL) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h expected %h", obs_all, BUBBLE_ALL);
    end
    rst_ = 1'b0;
    tick(); // first capture on the edge after release
    tests_run++;
    if (ex_pc !== 32'hABCD_0000 || ex_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_capture: got pc=%h v=%b expected pc=abcd0000 v=1", ex_pc, ex_valid);
    end
  endtask

  task automatic test_normal();
    drive(1'b1, 32'h10, 32'h4, 7'b0010011, 3'h0, 7'h0, 5'd1, 5'd2, 5'd3);
    tick();
    tests_run++;
    if (obs_all !== {1'b1, 32'h10, 32'h4, 7'b0010011, 3'h0, 7'h0, 5'd1, 5'd2, 5'd3}) begin
      tests_failed++;
      $display("FAIL normal_transfer: got %h expected %h", obs_all,
               {1'b1, 32'h10, 32'h4, 7'b0010011, 3'h0, 7'h0, 5'd1, 5'd2, 5'd3});
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'b1100011, 3'h7, 7'h7F, 5'd31, 5'd30, 5'd29);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (ex_pc !== 32'h10 || ex_imm !== 32'h4 || ex_rd_addr !== 5'd3) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: got pc=%h imm=%h rd=%0d expected pc=10 imm=4 rd=3",
                 i, ex_pc, ex_imm, ex_rd_addr);
      end
    end
    stall = 1'b0;
    tick();
    tests_run++;
    if (obs_all !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 7'b1100011, 3'h7, 7'h7F, 5'd31, 5'd30, 5'd29}) begin
      tests_failed++;
      $display("FAIL stall_release_load: got %h", obs_all);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h200, 32'h8, 7'b0000011, 3'h2, 7'h0, 5'd4, 5'd5, 5'd6);
    flush = 1'b1;
    tick();
    tests_run++;
    if (obs_all !== BUBBLE_ALL) begin
      tests_failed++;
      $display("FAIL flush_bubble: got %h expected %h", obs_all, BUBBLE_ALL);
    end
    flush = 1'b0;
    tick();
    tests_run++;
    if (obs_all !== {1'b1, 32'h200, 32'h8, 7'b0000011, 3'h2, 7'h0, 5'd4, 5'd5, 5'd6}) begin
      tests_failed++;
      $display("FAIL flush_reload: got %h", obs_all);
    end
  endtask

  task automatic test_flush_stall();
    drive(1'b1, 32'h300, 32'hC, 7'b1101111, 3'h0, 7'h0, 5'd0, 5'd0, 5'd1);
    stall = 1'b1;
    flush = 1'b1;
    tick();
    tests_run++;
    if (obs_all !== BUBBLE_ALL) begin
      tests_failed++;
      $display("FAIL flush_over_stall: got %h expected %h", obs_all, BUBBLE_ALL);
    end
`ifdef ID_EX_PERF_CNT_EN
    tests_run++;
    if (stall_cnt !== exp_stall_cnt || flush_cnt !== exp_flush_cnt) begin
      tests_failed++;
      $display("FAIL perf_counts: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               stall_cnt, flush_cnt, exp_stall_cnt, exp_flush_cnt);
    end
`endif
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_invalid_capture();
    drive(1'b0, 32'h444, 32'h55, 7'b0110111, 3'h1, 7'h1, 5'd10, 5'd11, 5'd12);
    tick();
    tests_run++;
    if (obs_all !== {1'b0, 32'h444, 32'h55, 7'b0110111, 3'h1, 7'h1, 5'd10, 5'd11, 5'd12}) begin
      tests_failed++;
      $display("FAIL invalid_payload_capture: got %h", obs_all);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h500, 32'h14, 7'b0010111, 3'h0, 7'h0, 5'd2, 5'd3, 5'd4);
    tick();
    tests_run++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h500) begin
      tests_failed++;
      $display("FAIL async_pre_load: got v=%b pc=%h expected v=1 pc=500", ex_valid, ex_pc);
    end
    stall = 1'b1;
    tick();
    #2;
    rst_ = 1'b1; // mid-cycle, during a stall
    exp_stall_cnt = '0;
    exp_flush_cnt = '0;
    #1;
    tests_run++;
    if (obs_all !== BUBBLE_ALL) begin
      tests_failed++;
      $display("FAIL async_mid_stall_reset: got %h expected %h", obs_all, BUBBLE_ALL);
    end
`ifdef ID_EX_PERF_CNT_EN
    tests_run++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      tests_failed++;
      $display("FAIL perf_reset_clear: got stall=%0d flush=%0d expected 0 0", stall_cnt, flush_cnt);
    end
`endif
    #3;
    rst_ = 1'b0;
    stall = 1'b0;
    tick();
    tests_run++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h500 || ex_imm !== 32'h14) begin
      tests_failed++;
      $display("FAIL async_post_release: got v=%b pc=%h imm=%h expected v=1 pc=500 imm=14",
               ex_valid, ex_pc, ex_imm);
    end
`ifdef ID_EX_PERF_CNT_EN
    stall = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    stall = 1'b0;
    flush = 1'b0;
    tests_run++;
    if (stall_cnt !== exp_stall_cnt || flush_cnt !== exp_flush_cnt) begin
      tests_failed++;
      $display("FAIL perf_recount: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               stall_cnt, flush_cnt, exp_stall_cnt, exp_flush_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_normal();
    test_stall();
    test_flush();
    test_flush_stall();
    test_invalid_capture();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
